// File: rtl/mbs_mc_sequencer.sv
// Multi-cycle instruction sequencer for the MBS core: per-phase datapath strobes,
// shared memory port with ack timeout, interrupt/trap entry and retired-instruction count.
module mbs_mc_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned TO_W        = 4,
   parameter int unsigned CNT_W       = 32,
   parameter bit          IRQ_EN      = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             stop,
   input  logic             pause,
   input  logic [2:0]       op_class,
   input  logic             irq,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_we,
   output logic             pc_we,
   output logic             alu_en,
   output logic             branch_en,
   output logic             reg_we,
   output logic             wb_sel_mem,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic             halted,
   output logic [CNT_W-1:0] instret,
   output logic [3:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EXE = 3'd3,
      S_MEM  = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6, S_HALT = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      OP_ALU = 3'd0, OP_BRANCH = 3'd1, OP_JUMP = 3'd2, OP_JAL = 3'd3,
      OP_LOAD = 3'd4, OP_STORE = 3'd5, OP_SYSCALL = 3'd6, OP_HALT = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      CAUSE_IRQ = 2'd0, CAUSE_SYSCALL = 2'd1, CAUSE_BUSERR = 2'd2
   } cause_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   state_t            state_q, state_d;
   cause_t            cause_q, cause_d;
   logic [TO_W-1:0]   wait_q, wait_d;
   logic              irq_pend_q, irq_pend_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic              paused, done, retire, irq_clr;
   op_t               op;

   assign op = op_t'(op_class);

   // pause only bites in states with no outstanding memory request and outside TRAP
   assign paused = pause && (state_q == S_IDLE || state_q == S_ID || state_q == S_EXE ||
                             state_q == S_WB   || state_q == S_HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cause_q    <= CAUSE_IRQ;
         wait_q     <= '0;
         irq_pend_q <= 1'b0;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         wait_q     <= wait_d;
         irq_pend_q <= irq_pend_d;
         instret_q  <= instret_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      wait_d  = '0;
      done    = 1'b0;
      retire  = 1'b0;
      irq_clr = 1'b0;
      if (stop) begin
         state_d = S_IDLE;
      end else if (paused) begin
         wait_d = wait_q;
      end else begin
         case (state_q)
            S_IDLE: if (run) state_d = S_IF;
            S_IF, S_MEM: begin
               if (mem_ack) begin
                  if (state_q == S_IF)        state_d = S_ID;
                  else if (op == OP_STORE)    done    = 1'b1;
                  else                        state_d = S_WB;
               end else if (wait_q == TO_LAST) begin
                  state_d = S_TRAP;
                  cause_d = CAUSE_BUSERR;
               end else begin
                  wait_d = wait_q + TO_W'(1);
               end
            end
            S_ID: begin
               case (op)
                  OP_HALT: begin
                     state_d = S_HALT;
                     retire  = 1'b1;
                  end
                  OP_SYSCALL: begin
                     state_d = S_TRAP;
                     cause_d = CAUSE_SYSCALL;
                  end
                  OP_JUMP: done    = 1'b1;
                  default: state_d = S_EXE;
               endcase
            end
            S_EXE: begin
               case (op)
                  OP_BRANCH, OP_JAL: done    = 1'b1;
                  OP_LOAD, OP_STORE: state_d = S_MEM;
                  default:           state_d = S_WB;
               endcase
            end
            S_WB: done = 1'b1;
            S_TRAP: begin
               state_d = S_IF;
               irq_clr = (cause_q == CAUSE_IRQ);
               retire  = (cause_q == CAUSE_SYSCALL);
            end
            S_HALT: if (!run) state_d = S_IDLE;
         endcase
      end
      // instruction boundary: retire, then take a pending interrupt before fetching
      if (done) begin
         retire = 1'b1;
         if (irq_pend_q) begin
            state_d = S_TRAP;
            cause_d = CAUSE_IRQ;
         end else if (run) begin
            state_d = S_IF;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   always_comb begin
      irq_pend_d = IRQ_EN && (irq || (irq_pend_q && !irq_clr));
      instret_d  = retire ? instret_q + CNT_W'(1) : instret_q;
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      alu_en     = 1'b0;
      branch_en  = 1'b0;
      reg_we     = 1'b0;
      wb_sel_mem = 1'b0;
      trap       = 1'b0;
      if (!paused) begin
         case (state_q)
            S_IF: begin
               mem_req = 1'b1;
               ir_we   = mem_ack;
            end
            S_ID: pc_we = (op == OP_JUMP);
            S_EXE: begin
               alu_en    = 1'b1;
               branch_en = (op == OP_BRANCH);
               reg_we    = (op == OP_JAL);
               pc_we     = (op == OP_JAL);
            end
            S_MEM: begin
               mem_req = 1'b1;
               mem_we  = (op == OP_STORE);
            end
            S_WB: begin
               reg_we     = 1'b1;
               wb_sel_mem = (op == OP_LOAD);
            end
            S_TRAP: begin
               trap  = 1'b1;
               pc_we = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign trap_cause = trap ? cause_q : 2'd0;
   assign halted     = (state_q == S_HALT);
   assign instret    = instret_q;
   assign state      = {1'b0, state_q};

endmodule

// File: tb/tb_mbs_mc_sequencer.sv
// Scoreboard bench for mbs_mc_sequencer: driver pushes per-cycle expected outputs from a
// phase-route reference model; an independent monitor pops and compares them.
module tb_mbs_mc_sequencer;

  localparam int unsigned TO  = 15;
  localparam int unsigned TOW = 4;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n, run, stop, pause, irq, mem_ack;
  logic [2:0]    op_class;
  logic          mem_req, mem_we, ir_we, pc_we, alu_en, branch_en, reg_we, wb_sel_mem, trap, halted;
  logic [1:0]    trap_cause;
  logic [CW-1:0] instret;
  logic [3:0]    state;

  always #5 clk = ~clk;

  mbs_mc_sequencer #(.MEM_TIMEOUT(TO), .TO_W(TOW), .CNT_W(CW), .IRQ_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .stop(stop), .pause(pause), .op_class(op_class),
    .irq(irq), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .alu_en(alu_en), .branch_en(branch_en), .reg_we(reg_we),
    .wb_sel_mem(wb_sel_mem), .trap(trap), .trap_cause(trap_cause), .halted(halted),
    .instret(instret), .state(state)
  );

  typedef struct packed {
    logic mem_req, mem_we, ir_we, pc_we, alu_en, branch_en, reg_we, wb_sel_mem, trap;
    logic [1:0] cause;
    logic       halted;
    logic [3:0] instret;
    logic [3:0] state;
  } obs_t;

  obs_t expq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   to_hits = 0;

  // phases each class walks through after decode (3=EXE 4=MEM 5=WB); empty = ends in decode
  int route[8][3] = '{'{3,5,0}, '{3,0,0}, '{0,0,0}, '{3,0,0}, '{3,4,5}, '{3,4,0}, '{0,0,0}, '{0,0,0}};
  int rlen[8]     = '{2, 1, 0, 1, 3, 2, 0, 0};

  int          m_ph, m_pos, m_w, m_cause;
  bit          m_pend;
  int unsigned m_ret;
  logic [2:0]  cur_cls;

  bit         g_rst = 1'b0, g_run = 1'b0, g_stop = 1'b0, g_pause = 1'b0, g_irq = 1'b0;
  int         g_ack = -1, g_ifw = 0, g_memw = 0;
  logic [2:0] g_cls = 3'd0;

  task automatic check(bit ok, string what);
    if (!ok) begin
      n_err++;
      $display("FAIL %s at %0t: state=%0d trap=%b cause=%0d instret=%0d", what, $time,
               state, trap, trap_cause, instret);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_pos = 0; m_w = 0; m_cause = 0; m_pend = 1'b0; m_ret = 0;
  endtask

  task automatic model_retire();
    m_ret = (m_ret + 1) % (1 << CW);
  endtask

  task automatic model_finish();
    model_retire();
    if (m_pend) begin
      m_ph = 6; m_cause = 0;
    end else m_ph = g_run ? 1 : 0;
  endtask

  task automatic model_advance();
    if (m_pos + 1 < rlen[cur_cls]) begin
      m_pos++;
      m_ph = route[cur_cls][m_pos];
    end else model_finish();
  endtask

  task automatic model_wait_or_timeout();
    if (m_w == TO - 1) begin
      m_ph = 6; m_cause = 2; m_w = 0;
    end else m_w++;
  endtask

  function automatic bit model_paused();
    return g_pause && (m_ph == 0 || m_ph == 2 || m_ph == 3 || m_ph == 5 || m_ph == 7);
  endfunction

  function automatic obs_t expect_now(logic a);
    obs_t e = '0;
    if (!model_paused()) begin
      case (m_ph)
        1: begin e.mem_req = 1'b1; e.ir_we = a; end
        2: e.pc_we = (cur_cls == 3'd2);
        3: begin
          e.alu_en    = 1'b1;
          e.branch_en = (cur_cls == 3'd1);
          e.reg_we    = (cur_cls == 3'd3);
          e.pc_we     = (cur_cls == 3'd3);
        end
        4: begin e.mem_req = 1'b1; e.mem_we = (cur_cls == 3'd5); end
        5: begin e.reg_we = 1'b1; e.wb_sel_mem = (cur_cls == 3'd4); end
        6: begin e.trap = 1'b1; e.pc_we = 1'b1; e.cause = 2'(m_cause); end
        default: ;
      endcase
    end
    e.halted  = (m_ph == 7);
    e.instret = 4'(m_ret);
    e.state   = 4'(m_ph);
    return e;
  endfunction

  task automatic model_update(logic a);
    bit npend;
    npend = g_irq || (m_pend && !(!g_stop && m_ph == 6 && m_cause == 0));
    if (g_stop) begin
      m_ph = 0; m_w = 0;
    end else if (!model_paused()) begin
      case (m_ph)
        0: if (g_run) m_ph = 1;
        1: if (a) begin m_ph = 2; m_w = 0; end else model_wait_or_timeout();
        2: begin
          if (cur_cls == 3'd7) begin m_ph = 7; model_retire(); end
          else if (cur_cls == 3'd6) begin m_ph = 6; m_cause = 1; end
          else if (rlen[cur_cls] == 0) model_finish();
          else begin m_pos = 0; m_ph = route[cur_cls][0]; end
        end
        3, 5: model_advance();
        4: if (a) begin m_w = 0; model_advance(); end else model_wait_or_timeout();
        6: begin if (m_cause == 1) model_retire(); m_ph = 1; end
        7: if (!g_run) m_ph = 0;
        default: ;
      endcase
    end
    m_pend = npend;
  endtask

  // one clock of stimulus; op_class only changes where no instruction is in flight
  task automatic step();
    logic a;
    obs_t e;
    if (m_ph == 0 || m_ph == 1 || m_ph == 6 || m_ph == 7) cur_cls = g_cls;
    if (g_ack >= 0) a = g_ack[0];
    else a = (m_ph == 1 && m_w >= g_ifw) || (m_ph == 4 && m_w >= g_memw);
    rst_n = g_rst; run = g_run; stop = g_stop; pause = g_pause; irq = g_irq;
    op_class = cur_cls; mem_ack = a;
    #1;
    if (!g_rst) model_reset();
    e = expect_now(a);
    expq.push_back(e);
    if (g_rst) model_update(a);
    @(negedge clk);
  endtask

  initial begin : monitor
    obs_t e, act;
    forever begin
      @(negedge clk);
      #3;
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        act = {mem_req, mem_we, ir_we, pc_we, alu_en, branch_en, reg_we, wb_sel_mem,
               trap, trap_cause, halted, instret, state};
        n_vec++;
        if (act !== e) begin
          n_err++;
          $display("FAIL cycle%0d: got=%05h exp=%05h (state %0d/%0d instret %0d/%0d)",
                   n_vec, act, e, act.state, e.state, act.instret, e.instret);
        end
      end
    end
  end

  initial begin : driver
    model_reset();
    cur_cls = 3'd0;
    rst_n = 1'b0; run = 1'b0; stop = 1'b0; pause = 1'b0; irq = 1'b0; mem_ack = 1'b0; op_class = 3'd0;
    @(negedge clk);
    check({mem_req, mem_we, ir_we, pc_we, alu_en, branch_en, reg_we, wb_sel_mem, trap,
           trap_cause, halted, instret, state} === '0, "reset state");
    g_run = 1'b1;
    repeat (2) step();
    g_rst = 1'b1;
    g_cls = 3'd0;
    repeat (6) step();
    g_cls = 3'd4; g_memw = 3;
    repeat (10) step();
    g_cls = 3'd0; g_memw = 0; g_ifw = 100;
    for (int i = 0; i < 18; i++) begin
      step();
      if (m_ph == 6) begin
        to_hits++;
        check(trap === 1'b1 && trap_cause === 2'd2 && instret === CW'(m_ret), "expired-wait bus-error trap");
      end
    end
    check(to_hits >= 1, "expired-wait trap occurred");
    g_ifw = 0;
    for (int i = 0; i < 10 && m_ph != 3; i++) step();
    g_irq = 1'b1; step(); g_irq = 1'b0;
    repeat (6) step();
    g_cls = 3'd4; g_memw = 5;
    for (int i = 0; i < 20 && m_ph != 4; i++) step();
    g_pause = 1'b1; g_ack = 0; step(); g_pause = 1'b0;
    g_stop = 1'b1; g_ack = 1; step(); g_stop = 1'b0; g_ack = -1;
    g_run = 1'b0; repeat (2) step(); g_run = 1'b1; g_memw = 0;
    for (int c = 1; c <= 5; c++) begin
      g_cls = 3'(c);
      repeat (8) step();
    end
    g_cls = 3'd0;
    repeat (70) step();
    g_cls = 3'd7;
    repeat (5) step();
    g_pause = 1'b1; step(); g_pause = 1'b0;
    g_run = 1'b0; repeat (3) step(); g_run = 1'b1;
    g_cls = 3'd0; g_ifw = 3;
    for (int i = 0; i < 10 && m_ph != 1; i++) step();
    step();
    g_rst = 1'b0; step(); g_rst = 1'b1; g_ifw = 0;
    for (int i = 0; i < 3000; i++) begin
      g_run   = ($urandom_range(0, 15) != 0);
      g_stop  = ($urandom_range(0, 39) == 0);
      g_pause = ($urandom_range(0, 5) == 0);
      g_irq   = ($urandom_range(0, 24) == 0);
      g_cls   = 3'($urandom_range(0, 7));
      g_ack   = ((i % 600) >= 575) ? 0 : (($urandom_range(0, 99) < 55) ? 1 : 0);
      step();
    end
    g_ack = -1; g_stop = 1'b0; g_pause = 1'b0; g_irq = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
